// File: rtl/ddc_pkg.sv
// ----------------------------------------------------------------------------
// ddc_pkg
// Shared constants and helper functions for the digital downconverter.
//   - PROD_W      : width of the mixer product (7-bit sample x 8-bit LUT)
//   - CIC_N       : CIC filter order (integrator / comb stage count)
//   - LUT_AW/W    : NCO lookup table address and data widths
//   - cic_width() : register width of a CIC branch for a given decimation
//   - sin_lut()   : round(127*sin(2*pi*k/256)), 8-bit signed
//   - cos_lut()   : round(127*cos(2*pi*k/256)), 8-bit signed
// ----------------------------------------------------------------------------
package ddc_pkg;

    localparam int PROD_W    = 15;
    localparam int CIC_N     = 3;
    localparam int LUT_AW    = 8;
    localparam int LUT_W     = 8;
    localparam int LUT_DEPTH = 1 << LUT_AW;

    // Quarter-wave table, entry k = round(127*sin(pi*k/128)) for k = 0..64.
    // The full 256-entry tables are built from this by quadrant symmetry so
    // the values are exact integers rather than tool-dependent real math.
    localparam logic [0:64][7:0] QSIN = {
        8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,
        8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
        8'd49,  8'd51,  8'd54,  8'd57,  8'd60,  8'd63,  8'd65,  8'd68,
        8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,  8'd85,  8'd88,
        8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
        8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116,
        8'd117, 8'd118, 8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124,
        8'd125, 8'd125, 8'd126, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127,
        8'd127
    };

    // Bit growth of an N-stage CIC with differential delay 1 is N*log2(R).
    function automatic int cic_width(input int decim);
        return PROD_W + CIC_N * $clog2(decim);
    endfunction

    function automatic logic signed [LUT_W-1:0] sin_lut(input logic [LUT_AW-1:0] idx);
        logic [6:0]              k;
        logic signed [LUT_W-1:0] mag;
        // Quadrants 1 and 3 run the quarter table backwards; 2 and 3 negate.
        k   = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
        mag = $signed(QSIN[k]);
        return idx[7] ? -mag : mag;
    endfunction

    function automatic logic signed [LUT_W-1:0] cos_lut(input logic [LUT_AW-1:0] idx);
        return sin_lut(idx + LUT_AW'(64));
    endfunction

endpackage

// File: rtl/ddc_mixer_cic_cic_decimator.sv
// ----------------------------------------------------------------------------
// cic_decimator
// One branch of a CIC_N-stage CIC decimator (differential delay 1).
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   din_i        : signed mixer product
//   din_valid_i  : din_i carries a sample this cycle; integrators advance
//   dump_i       : qualifies the sample that completes a decimation block
//   dout_o       : truncated comb output, valid while dout_valid_o is high
//   dout_valid_o : one-cycle strobe, comb chain evaluated this cycle
// Integrators wrap in two's complement by design; the comb differences
// recover the exact result as long as CIC_W holds the full bit growth.
// ----------------------------------------------------------------------------
module cic_decimator
    import ddc_pkg::*;
#(
    parameter int DECIM = 64,
    parameter int OUT_W = 16
)(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [PROD_W-1:0] din_i,
    input  logic                     din_valid_i,
    input  logic                     dump_i,
    output logic signed [OUT_W-1:0]  dout_o,
    output logic                     dout_valid_o
);

    localparam int CIC_W = cic_width(DECIM);

    logic signed [CIC_W-1:0] integ_q    [CIC_N];
    logic signed [CIC_W-1:0] integ_d    [CIC_N];
    logic signed [CIC_W-1:0] comb_dly_q [CIC_N];
    logic signed [CIC_W-1:0] comb_stage [CIC_N+1];
    logic signed [CIC_W-1:0] din_ext;
    logic                    dump_q;

    // Integrators cascade within one cycle: each stage adds the already
    // updated value of the stage before it, so the chain is a pure
    // triple running sum with no extra inter-stage delay.
    always_comb begin
        din_ext    = CIC_W'(din_i);
        integ_d[0] = integ_q[0] + din_ext;
        for (int k = 1; k < CIC_N; k++) begin
            integ_d[k] = integ_q[k] + integ_d[k-1];
        end
    end

    // Comb chain evaluated combinationally from the last integrator; the
    // delay registers only advance on the decimated strobe.
    always_comb begin
        comb_stage[0] = integ_q[CIC_N-1];
        for (int k = 0; k < CIC_N; k++) begin
            comb_stage[k+1] = comb_stage[k] - comb_dly_q[k];
        end
        dout_o = comb_stage[CIC_N][CIC_W-1 -: OUT_W];
    end

    assign dout_valid_o = dump_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dump_q <= 1'b0;
            for (int k = 0; k < CIC_N; k++) begin
                integ_q[k]    <= '0;
                comb_dly_q[k] <= '0;
            end
        end else begin
            dump_q <= din_valid_i & dump_i;
            for (int k = 0; k < CIC_N; k++) begin
                if (din_valid_i) begin
                    integ_q[k] <= integ_d[k];
                end
                if (dump_q) begin
                    comb_dly_q[k] <= comb_stage[k];
                end
            end
        end
    end

endmodule

// File: rtl/ddc_mixer_cic.sv
// ----------------------------------------------------------------------------
// ddc_mixer_cic
// Digital downconverter: offset-binary ADC samples are mixed with an NCO to
// complex baseband and decimated by DECIM through matched CIC branches.
//   i_sysclk_40 : 40 MHz system clock
//   i_rst       : synchronous active-high reset
//   i_adc_data  : ADC sample, offset binary (0 = most negative)
//   i_adc_dv    : sample qualifier, one sample per high cycle
//   i_ftw       : NCO tuning word, sampled with each valid sample
//   o_i / o_q   : signed baseband I/Q, held between strobes
//   o_dv        : one-cycle strobe, 4 cycles after the block's last sample
// Pipeline: LUT/convert reg -> product reg -> integrators -> comb + output.
// ----------------------------------------------------------------------------
module ddc_mixer_cic
    import ddc_pkg::*;
#(
    parameter int ADC_W   = 7,
    parameter int PHASE_W = 32,
    parameter int DECIM   = 64,
    parameter int OUT_W   = 16
)(
    input  logic                    i_sysclk_40,
    input  logic                    i_rst,
    input  logic [ADC_W-1:0]        i_adc_data,
    input  logic                    i_adc_dv,
    input  logic [PHASE_W-1:0]      i_ftw,
    output logic signed [OUT_W-1:0] o_i,
    output logic signed [OUT_W-1:0] o_q,
    output logic                    o_dv
);

    localparam int CNT_W = $clog2(DECIM);

    // NCO tables; synthesis folds the constant function calls into ROMs
    logic signed [LUT_W-1:0] cos_rom [LUT_DEPTH];
    logic signed [LUT_W-1:0] sin_rom [LUT_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
            assign cos_rom[gi] = cos_lut(LUT_AW'(gi));
            assign sin_rom[gi] = sin_lut(LUT_AW'(gi));
        end
    endgenerate

    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     cnt_wrap;
    logic [LUT_AW-1:0]        lut_idx;
    logic signed [ADC_W-1:0]  samp_d, samp_q;
    logic signed [LUT_W-1:0]  cos_q, sin_q;
    logic                     dv1_q, last1_q, dv2_q, last2_q;
    logic signed [PROD_W-1:0] prod_i_d, prod_i_q, prod_q_d, prod_q_q;
    logic signed [OUT_W-1:0]  cic_i_dout, cic_q_dout;
    logic                     cic_i_vld, cic_q_vld;
    logic signed [OUT_W-1:0]  o_i_q, o_q_q;
    logic                     o_dv_q;

    always_comb begin
        // Flipping the MSB turns offset binary into two's complement
        samp_d   = {~i_adc_data[ADC_W-1], i_adc_data[ADC_W-2:0]};
        lut_idx  = phase_q[PHASE_W-1 -: LUT_AW];
        cnt_wrap = (cnt_q == CNT_W'(DECIM - 1));
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        if (i_adc_dv) begin
            phase_d = phase_q + i_ftw;
            cnt_d   = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        end
        prod_i_d = PROD_W'(samp_q) * PROD_W'(cos_q);
        prod_q_d = -(PROD_W'(samp_q) * PROD_W'(sin_q));
    end

    // Control path: everything that must clear on reset
    always_ff @(posedge i_sysclk_40) begin
        if (i_rst) begin
            phase_q <= '0;
            cnt_q   <= '0;
            dv1_q   <= 1'b0;
            last1_q <= 1'b0;
            dv2_q   <= 1'b0;
            last2_q <= 1'b0;
            o_i_q   <= '0;
            o_q_q   <= '0;
            o_dv_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            dv1_q   <= i_adc_dv;
            last1_q <= i_adc_dv & cnt_wrap;
            dv2_q   <= dv1_q;
            last2_q <= last1_q;
            o_dv_q  <= cic_i_vld & cic_q_vld;
            if (cic_i_vld) begin
                o_i_q <= cic_i_dout;
            end
            if (cic_q_vld) begin
                o_q_q <= cic_q_dout;
            end
        end
    end

    // Data path: qualified by the valid pipeline, so no reset is needed and
    // the table read stays a plain registered ROM access.
    always_ff @(posedge i_sysclk_40) begin
        if (i_adc_dv) begin
            samp_q <= samp_d;
            cos_q  <= cos_rom[lut_idx];
            sin_q  <= sin_rom[lut_idx];
        end
        prod_i_q <= prod_i_d;
        prod_q_q <= prod_q_d;
    end

    cic_decimator #(
        .DECIM (DECIM),
        .OUT_W (OUT_W)
    ) u_cic_i (
        .clk_i        (i_sysclk_40),
        .rst_i        (i_rst),
        .din_i        (prod_i_q),
        .din_valid_i  (dv2_q),
        .dump_i       (last2_q),
        .dout_o       (cic_i_dout),
        .dout_valid_o (cic_i_vld)
    );

    cic_decimator #(
        .DECIM (DECIM),
        .OUT_W (OUT_W)
    ) u_cic_q (
        .clk_i        (i_sysclk_40),
        .rst_i        (i_rst),
        .din_i        (prod_q_q),
        .din_valid_i  (dv2_q),
        .dump_i       (last2_q),
        .dout_o       (cic_q_dout),
        .dout_valid_o (cic_q_vld)
    );

    assign o_i  = o_i_q;
    assign o_q  = o_q_q;
    assign o_dv = o_dv_q;

endmodule

// File: tb/tb_ddc_mixer_cic.sv
// ----------------------------------------------------------------------------
// tb_ddc_mixer_cic
// Directed bench for ddc_mixer_cic with hand-computed expected values.
// DC gain is 64^3 = 2^18 and the output keeps bits [32:17], so a steady
// constant product P reads back as 2*P:
//   code 127 -> s=+63, P=63*127=8001   -> o_i=16002
//   code 0   -> s=-64, P=-64*127=-8128 -> o_i=-16256
// An fs/4 tone (ftw=2^30) steps the LUT 0,64,128,192 and sums to zero over
// every 64-sample window.
// ----------------------------------------------------------------------------
module tb_ddc_mixer_cic;

    localparam int          DECIM   = 64;
    localparam logic [31:0] FTW_FS4 = 32'h4000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic [6:0]         adc_data;
    logic               adc_dv;
    logic [31:0]        ftw;
    logic signed [15:0] dut_i;
    logic signed [15:0] dut_q;
    logic               dut_dv;

    always #5 clk = ~clk;

    ddc_mixer_cic dut (
        .i_sysclk_40 (clk),
        .i_rst       (rst),
        .i_adc_data  (adc_data),
        .i_adc_dv    (adc_dv),
        .i_ftw       (ftw),
        .o_i         (dut_i),
        .o_q         (dut_q),
        .o_dv        (dut_dv)
    );

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc           = 0;
    int valid_cnt     = 0;
    int out_idx       = 0;
    int pend[$];

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Drive one cycle, let the edge take it, then look #1 after the edge.
    // pend records the cycle of every sample that closes a block.
    task automatic step(input logic r, input logic dv, input logic [6:0] d,
                        input logic [31:0] tw);
        rst      = r;
        adc_dv   = dv;
        adc_data = d;
        ftw      = tw;
        @(posedge clk);
        #1;
        if (r) begin
            valid_cnt = 0;
            out_idx   = 0;
            pend.delete();
        end else if (dv) begin
            valid_cnt++;
            if (valid_cnt % DECIM == 0) pend.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic do_reset(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1, (k % 2 == 0), 7'($urandom_range(0, 127)), $urandom);
            check({tag, "_rst_i"},  dut_i,  0);
            check({tag, "_rst_q"},  dut_q,  0);
            check({tag, "_rst_dv"}, dut_dv, 0);
        end
        step(1'b0, 1'b0, 7'd0, 32'd0);
        check({tag, "_rel_i"},  dut_i,  0);
        check({tag, "_rel_q"},  dut_q,  0);
        check({tag, "_rel_dv"}, dut_dv, 0);
    endtask

    task automatic run_case(input string name, input logic [6:0] d,
                            input logic [31:0] tw, input bit every_cycle,
                            input int n_out, input int exp_i, input int exp_q,
                            input int first_chk);
        int period   = every_cycle ? DECIM : 2 * DECIM;
        int budget   = (n_out + 1) * period + 20;
        int seen     = 0;
        int prev     = -1;
        int hold_err = 0;
        logic signed [15:0] held_i = '0;
        logic signed [15:0] held_q = '0;
        for (int k = 0; k < budget && seen < n_out; k++) begin
            step(1'b0, every_cycle ? 1'b1 : (k % 2 == 0), d, tw);
            if (dut_dv) begin
                seen++;
                out_idx++;
                $display("%s out %0d @cycle %0d: i=%0d q=%0d", name, out_idx, cyc, dut_i, dut_q);
                check({name, "_dv_expected"}, (pend.size() > 0), 1);
                if (pend.size() > 0) check({name, "_latency"}, cyc - pend.pop_front(), 4);
                if (prev >= 0) check({name, "_period"}, cyc - prev, period);
                prev = cyc;
                if (out_idx >= first_chk) begin
                    check({name, "_i"}, dut_i, exp_i);
                    check({name, "_q"}, dut_q, exp_q);
                end
                held_i = dut_i;
                held_q = dut_q;
            end else if (out_idx > 0 && (dut_i !== held_i || dut_q !== held_q)) begin
                hold_err++;
            end
        end
        check({name, "_count"}, seen, n_out);
        check({name, "_hold"}, hold_err, 0);
    endtask

    initial begin
        int dv_during;
        rst      = 1'b1;
        adc_dv   = 1'b0;
        adc_data = '0;
        ftw      = '0;

        do_reset("init", 5);
        run_case("dc_pos", 7'd127, 32'd0, 1'b0, 5, 16002, 0, 3);

        do_reset("r2", 1);
        run_case("dc_neg", 7'd0, 32'd0, 1'b0, 5, -16256, 0, 3);

        do_reset("r3", 1);
        run_case("dc_zero", 7'd64, 32'd0, 1'b0, 4, 0, 0, 1);

        do_reset("r4", 1);
        run_case("fs4", 7'd127, FTW_FS4, 1'b0, 5, 0, 0, 3);

        do_reset("r5", 1);
        run_case("b2b", 7'd127, 32'd0, 1'b1, 5, 16002, 0, 3);

        // 30 samples of an fs/4 tone leave the phase at index 128; if the
        // reset failed to clear it, the DC run below would read -16002.
        do_reset("r6", 1);
        dv_during = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b0, (k % 2 == 0), 7'd127, FTW_FS4);
            if (dut_dv) dv_during++;
        end
        check("mid_partial_dv", dv_during, 0);
        step(1'b1, 1'b0, 7'd127, 32'd0);
        check("mid_rst_dv", dut_dv, 0);
        run_case("mid_rst", 7'd127, 32'd0, 1'b0, 4, 16002, 0, 3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/ddc_mixer_cic.md
# ddc_mixer_cic

Digital downconverter placed directly after the LTC1406 ADC driver. Takes the 7-bit offset-binary samples and per-cycle valid qualifier produced at 20 MSPS on the 40 MHz system clock. Mixes each sample with a numerically controlled oscillator (NCO) to complex baseband, then decimates I and Q through matched 3-stage CIC filters, producing signed 16-bit I/Q samples for the FM demodulator.

## Interface
- ADC_W, 7, input sample width (offset binary)
- PHASE_W, 32, NCO phase accumulator width
- DECIM, 64, CIC decimation ratio; power of two, 4..1024
- OUT_W, 16, output I/Q width
- i_sysclk_40  in  1  system clock, 40 MHz; the only clock
- i_rst  in  1  reset, synchronous, active-high
- i_adc_data  in  ADC_W  ADC sample, offset binary (0 = most negative)
- i_adc_dv  in  1  sample qualifier; each high cycle is one sample
- i_ftw  in  PHASE_W  NCO frequency tuning word; f = ftw·20 MHz / 2^PHASE_W
- o_i  out  OUT_W  baseband in-phase sample, signed
- o_q  out  OUT_W  baseband quadrature sample, signed
- o_dv  out  1  one-cycle pulse, o_i/o_q valid

## Operation
- Conversion: signed sample s = i_adc_data with MSB inverted (code 64 -> 0, 127 -> +63, 0 -> -64).
- NCO: phase register p, reset 0. On each i_adc_dv cycle the sample uses the current p; then p <= p + i_ftw (mod 2^PHASE_W). i_ftw is sampled on that same cycle; a change affects the next sample. No update when i_adc_dv is low.
- LUT index = p[PHASE_W-1 -: 8]; cos[k] = round(127·cos(2πk/256)), sin[k] likewise, 8-bit signed.
- Mixer: I product = s·cos, Q product = −(s·sin); PROD_W = 15 bits signed, full precision.
- CIC per branch: N = 3 integrators run only on sample-valid cycles. A decimation counter (0..DECIM-1, reset 0) fires on the DECIM-th product. Then 3 comb stages (differential delay 1) run once. CIC_W = 15 + 3·log2(DECIM) bits (33 for DECIM=64). Two's-complement wrap in integrators is intended; no saturation.
- Output: o_i/o_q = comb result bits [CIC_W-1 -: OUT_W] (truncation, no rounding). DC gain is DECIM^3 before truncation.
- No backpressure. Downstream must accept o_dv every time it fires.
- Reset: p, counter, all integrators, comb delays, o_i, o_q and o_dv go to 0 on the cycle after i_rst is sampled high. Reset mid-block discards the partial block; counting restarts from sample 0.

## Timing
- Pipeline: cycle 0 = i_adc_dv high (convert + LUT register), cycle 1 multiply register, cycle 2 integrator update. For the DECIM-th sample: cycle 3 comb stages registered, cycle 4 output register. o_dv is high during cycle 4 only.
- Fixed latency: o_dv rises 4 cycles after the cycle where the DECIM-th i_adc_dv was high.
- Throughput: one sample per cycle is supported; nominal rate is every other cycle, giving o_dv once per 2·DECIM cycles (128 for DECIM=64).
- o_i/o_q hold their value between o_dv pulses.
- CIC transient: the first 2 outputs after reset are partial. Output 3 onward is steady state.

## Structure
- ddc_pkg: cos/sin LUT generation function (256 entries, 8-bit signed), PROD_W, CIC order constant (3), and a function computing CIC_W from DECIM.
- Sub-module cic_decimator: one branch (integrators, decimation strobe input, combs, truncation). Instantiated twice; the decimation counter is shared in the top level.
- Top level ddc_mixer_cic: conversion, NCO, LUT, mixer, counter and output registers.

## Test plan
- Reset: hold i_rst 5 cycles with random i_adc_data and i_adc_dv toggling -> o_i=0, o_q=0, o_dv=0 throughout and on the first cycle after release.
- DC, zero tune: i_ftw=0, i_adc_data=127, i_adc_dv toggling every cycle -> o_dv every 128 cycles; from output 3 on, o_i=16002, o_q=0. Check latency is exactly 4 cycles after the 64th valid.
- Negative DC: i_ftw=0, i_adc_data=0 -> steady o_i=−16256, o_q=0. Same setup with i_adc_data=64 -> o_i=o_q=0 for every output.
- fs/4 tone rejection: i_ftw=2^30, i_adc_data=127 -> LUT index sequence 0,64,128,192; steady-state o_i=0, o_q=0.
- Back-to-back valid: i_adc_dv held high continuously -> o_dv every 64 cycles, same steady-state values as the DC test.
- Reset mid-block: i_rst for 1 cycle after 30 samples -> no o_dv for the partial block; first o_dv comes 4 cycles after the 64th post-reset valid; phase restarts at 0.
